// File: rtl/rvx_board_pkg.sv
// Shared board-level definitions: time constants, debounce sizing helper and
// the per-channel debounce FSM state type.
package rvx_board_pkg;

  localparam int US_PER_S = 1000000;

  typedef enum logic {
    DEBOUNCE_STABLE   = 1'b0,
    DEBOUNCE_COUNTING = 1'b1
  } debounce_state_t;

  // Clock cycles a level must hold before it is accepted; never less than one.
  function automatic int debounce_cycles(input int clock_frequency, input int debounce_time_us);
    int cycles;
    cycles = clock_frequency / US_PER_S * debounce_time_us;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchroniser, stability counter FSM and,
// when BUTTON_DEBOUNCER_EDGES_EN is defined, registered rise/fall pulses.
module debounce_channel
  import rvx_board_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1,
  parameter int   COUNTER_WIDTH   = 1,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_raw,
  output logic            o_debounced,
  output logic            o_rise_pulse,
  output logic            o_fall_pulse,
  output debounce_state_t o_state
);

  localparam logic [COUNTER_WIDTH-1:0] LAST_COUNT = COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_debounced;
  logic [COUNTER_WIDTH-1:0] r_count;
  debounce_state_t          r_state;
  logic                     w_mismatch;

  assign w_mismatch = r_sync2 ^ r_debounced;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= RESET_LEVEL;
      r_sync2     <= RESET_LEVEL;
      r_debounced <= RESET_LEVEL;
      r_count     <= '0;
      r_state     <= DEBOUNCE_STABLE;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      unique case (r_state)
        DEBOUNCE_STABLE: begin
          if (w_mismatch) begin
            // A one-cycle qualification accepts the new level immediately.
            if (r_count == LAST_COUNT) begin
              r_debounced <= ~r_debounced;
            end else begin
              r_count <= r_count + 1'b1;
              r_state <= DEBOUNCE_COUNTING;
            end
          end
        end
        DEBOUNCE_COUNTING: begin
          if (!w_mismatch) begin
            r_count <= '0;
            r_state <= DEBOUNCE_STABLE;
          end else if (r_count == LAST_COUNT) begin
            r_debounced <= ~r_debounced;
            r_count     <= '0;
            r_state     <= DEBOUNCE_STABLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        default: begin
          r_count <= '0;
          r_state <= DEBOUNCE_STABLE;
        end
      endcase
    end
  end

`ifdef BUTTON_DEBOUNCER_EDGES_EN
  logic r_debounced_d;
  logic r_rise_pulse;
  logic r_fall_pulse;

  // The delayed copy resets to the same level as the output, so reset release
  // can never look like an edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_debounced_d <= RESET_LEVEL;
      r_rise_pulse  <= 1'b0;
      r_fall_pulse  <= 1'b0;
    end else begin
      r_debounced_d <= r_debounced;
      r_rise_pulse  <= r_debounced & ~r_debounced_d;
      r_fall_pulse  <= ~r_debounced & r_debounced_d;
    end
  end

  assign o_rise_pulse = r_rise_pulse;
  assign o_fall_pulse = r_fall_pulse;
`else
  assign o_rise_pulse = 1'b0;
  assign o_fall_pulse = 1'b0;
`endif

  assign o_debounced = r_debounced;
  assign o_state     = r_state;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button/switch conditioner: one debounce_channel per input.
// Edge pulses are present only when BUTTON_DEBOUNCER_EDGES_EN is defined.
module button_debouncer
  import rvx_board_pkg::*;
#(
  parameter int   NUM_INPUTS       = 1,
  parameter int   CLOCK_FREQUENCY  = 12000000,
  parameter int   DEBOUNCE_TIME_US = 10000,
  parameter logic RESET_LEVEL      = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] raw_input,
  output logic [NUM_INPUTS-1:0] debounced,
  output logic [NUM_INPUTS-1:0] rise_pulse,
  output logic [NUM_INPUTS-1:0] fall_pulse,
  output logic [NUM_INPUTS-1:0] debug_state
);

  localparam int DEBOUNCE_CYCLES = debounce_cycles(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);
  localparam int COUNTER_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1);

  debounce_state_t w_state [NUM_INPUTS];

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_channel
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .COUNTER_WIDTH   (COUNTER_WIDTH),
      .RESET_LEVEL     (RESET_LEVEL)
    ) u_channel (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_raw        (raw_input[g]),
      .o_debounced  (debounced[g]),
      .o_rise_pulse (rise_pulse[g]),
      .o_fall_pulse (fall_pulse[g]),
      .o_state      (w_state[g])
    );

    // One bit per channel: high while that channel is qualifying a new level.
    assign debug_state[g] = (w_state[g] == DEBOUNCE_COUNTING);
  end

endmodule
